// File: rtl/fb_rect_writer.sv
// Rectangle fill engine for the VRAM frame buffer.
// Turns a corner/colour command into a row-major stream of single-pixel
// writes, issuing writes only while the blanking permission is high.
module fb_rect_writer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 360,
    parameter int ADDR_WIDTH    = 18,
    parameter int DATA_WIDTH    = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [9:0]            i_x0,
    input  logic [8:0]            i_y0,
    input  logic [9:0]            i_x1,
    input  logic [8:0]            i_y1,
    input  logic [DATA_WIDTH-1:0] i_colour,
    input  logic                  i_blank,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_write
);

    typedef enum logic [1:0] {IDLE, INIT, DRAW, DONE} state_t;

    localparam logic [9:0]            X_LAST = 10'(SCREEN_WIDTH - 1);
    localparam logic [8:0]            Y_LAST = 9'(SCREEN_HEIGHT - 1);
    localparam logic [10:0]           X_END  = 11'(SCREEN_WIDTH);
    localparam logic [9:0]            Y_END  = 10'(SCREEN_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(SCREEN_WIDTH);

    state_t                state_q, state_d;
    logic [9:0]            x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [8:0]            y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
    logic [DATA_WIDTH-1:0] colour_q, colour_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d, cur_addr_q, cur_addr_d;
    logic                  busy_q, busy_d, done_q, done_d, write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [9:0]            x1_clamp;
    logic [8:0]            y1_clamp;
    logic                  cmd_empty;
    logic [ADDR_WIDTH-1:0] first_addr;

    assign x1_clamp  = (i_x1 > X_LAST) ? X_LAST : i_x1;
    assign y1_clamp  = (i_y1 > Y_LAST) ? Y_LAST : i_y1;
    assign cmd_empty = (i_x0 > x1_clamp) || (i_y0 > y1_clamp) ||
                       ({1'b0, i_x0} >= X_END) || ({1'b0, i_y0} >= Y_END);
    // Single multiply: start address of the first row.
    assign first_addr = ADDR_WIDTH'(y0_q) * STRIDE + ADDR_WIDTH'(x0_q);

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            x1_q       <= '0;
            cx_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            cy_q       <= '0;
            colour_q   <= '0;
            row_base_q <= '0;
            cur_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            cx_q       <= cx_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            cy_q       <= cy_d;
            colour_q   <= colour_d;
            row_base_q <= row_base_d;
            cur_addr_q <= cur_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Next-state and output logic; write/done are single-cycle unless re-asserted.
    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        cx_d       = cx_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        cy_d       = cy_q;
        colour_d   = colour_q;
        row_base_d = row_base_q;
        cur_addr_d = cur_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        write_d    = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    x0_d     = i_x0;
                    y0_d     = i_y0;
                    x1_d     = x1_clamp;
                    y1_d     = y1_clamp;
                    colour_d = i_colour;
                    if (cmd_empty) begin
                        state_d = DONE;
                    end else begin
                        state_d = INIT;
                        busy_d  = 1'b1;
                    end
                end
            end
            INIT: begin
                row_base_d = first_addr;
                cur_addr_d = first_addr;
                cx_d       = x0_q;
                cy_d       = y0_q;
                state_d    = DRAW;
            end
            DRAW: begin
                // Without blanking permission everything holds (stall).
                if (i_blank) begin
                    write_d = 1'b1;
                    addr_d  = cur_addr_q;
                    data_d  = colour_q;
                    if (cx_q < x1_q) begin
                        cx_d       = cx_q + 10'd1;
                        cur_addr_d = cur_addr_q + 1'b1;
                    end else if (cy_q < y1_q) begin
                        cx_d       = x0_q;
                        cy_d       = cy_q + 9'd1;
                        row_base_d = row_base_q + STRIDE;
                        cur_addr_d = row_base_q + STRIDE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_write = write_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Bench for fb_rect_writer: each fill is checked cycle by cycle against a
// reference built from the pixel list of the clamped rectangle.
module tb_fb_rect_writer;

    localparam int SW = 640;
    localparam int SH = 360;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] x0 = '0, x1 = '0;
    logic [8:0] y0 = '0, y1 = '0;
    logic [5:0] colour = '0;
    logic       blank = 1'b1;
    logic       busy, done, wr;
    logic [17:0] addr;
    logic [5:0]  data;

    int total = 0;
    int bad   = 0;

    fb_rect_writer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_x0(x0), .i_y0(y0), .i_x1(x1), .i_y1(y1),
        .i_colour(colour), .i_blank(blank),
        .o_busy(busy), .o_done(done), .o_addr(addr), .o_data(data), .o_write(wr)
    );

    always #5 clk = ~clk;

    // mode 0: blank always high; 1: three-cycle stall after second write; 2: random blank
    task automatic do_fill(input int cx0, input int cy0, input int cx1, input int cy1,
                           input int col, input int mode, input bit mid_start);
        int  exp_q[$];
        int  xe, ye, remaining, last_c, done_c, wcount, stall, a;
        bit  nonempty, blank_prev, exp_w, exp_done, exp_busy, finished, nb;
        xe = (cx1 > SW - 1) ? SW - 1 : cx1;
        ye = (cy1 > SH - 1) ? SH - 1 : cy1;
        for (int y = cy0; y <= ye; y++)
            for (int x = cx0; x <= xe; x++)
                exp_q.push_back(y * SW + x);
        nonempty  = (exp_q.size() > 0);
        remaining = exp_q.size();
        last_c = -1; done_c = -1; wcount = 0; stall = 0;
        blank_prev = 1'b1; finished = 1'b0;
        @(negedge clk);
        x0 = 10'(cx0); y0 = 9'(cy0); x1 = 10'(cx1); y1 = 9'(cy1);
        colour = 6'(col); blank = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            exp_w = (c >= 2) && blank_prev && (remaining > 0);
            total++;
            if (wr !== exp_w) begin
                bad++;
                $display("FAIL write_en cycle %0d: got %b want %b", c, wr, exp_w);
            end
            if (exp_w) begin
                a = exp_q.pop_front();
                total++;
                if (addr !== 18'(a)) begin
                    bad++;
                    $display("FAIL addr write %0d: got %0d want %0d", wcount, addr, a);
                end
                total++;
                if (data !== 6'(col)) begin
                    bad++;
                    $display("FAIL data write %0d: got %0h want %0h", wcount, data, col);
                end
                remaining--;
                wcount++;
                if (remaining == 0) last_c = c;
            end
            exp_done = nonempty ? (last_c >= 0 && c == last_c + 1) : (c == 1);
            exp_busy = nonempty && !(remaining == 0 && c > last_c);
            total++;
            if (done !== exp_done) begin
                bad++;
                $display("FAIL done cycle %0d: got %b want %b", c, done, exp_done);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL busy cycle %0d: got %b want %b", c, busy, exp_busy);
            end
            if (exp_done) done_c = c;
            if (done_c >= 0 && c == done_c + 1) begin
                finished = 1'b1;
                break;
            end
            nb = 1'b1;
            if (mode == 1) begin
                if (exp_w && wcount == 2) stall = 3;
                if (stall > 0) begin
                    nb = 1'b0;
                    stall--;
                end
            end else if (mode == 2) begin
                nb = ($urandom_range(0, 3) != 0);
            end
            blank = nb;
            blank_prev = nb;
            if (mid_start && c == 4) begin
                x0 = 10'd100; y0 = 9'd100; x1 = 10'd120; y1 = 9'd110;
                colour = 6'h3F;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        blank = 1'b1;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL fill_timeout: got no completion want done after %0d writes", exp_q.size() + wcount);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (wr !== 1'b0)     begin bad++; $display("FAIL reset_write: got %b want 0", wr); end
        total++; if (addr !== 18'd0)  begin bad++; $display("FAIL reset_addr: got %0d want 0", addr); end
        total++; if (data !== 6'd0)   begin bad++; $display("FAIL reset_data: got %0d want 0", data); end
        rst = 1'b0;
    endtask

    task automatic test_single();     do_fill(0, 0, 0, 0, 'h15, 0, 1'b0);           endtask
    task automatic test_small_rect(); do_fill(10, 2, 12, 3, 'h2A, 0, 1'b0);         endtask
    task automatic test_clamp();      do_fill(638, 359, 700, 400, 'h07, 0, 1'b0);   endtask
    task automatic test_empty();
        do_fill(20, 5, 10, 6, 'h11, 0, 1'b0);
        do_fill(650, 0, 700, 0, 'h11, 0, 1'b0);
        do_fill(0, 370, 5, 380, 'h11, 0, 1'b0);
    endtask
    task automatic test_stall();      do_fill(0, 0, 3, 0, 'h33, 1, 1'b1);           endtask

    task automatic test_reset_mid();
        int n = 0;
        int viol = 0;
        @(negedge clk);
        x0 = 10'd0; y0 = 9'd0; x1 = 10'd9; y1 = 9'd9; colour = 6'h1C;
        blank = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr === 1'b1) n++;
            if (n == 12) break;
        end
        total++;
        if (n !== 12) begin bad++; $display("FAIL rst_mid_progress: got %0d writes want 12", n); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (wr !== 1'b0)   begin bad++; $display("FAIL rst_mid_write: got %b want 0", wr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done: got %b want 0", done); end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr !== 1'b0 || done !== 1'b0 || busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", viol); end
        do_fill(3, 2, 5, 3, 'h2B, 0, 1'b0);
    endtask

    task automatic test_random();
        int rx0, ry0, rx1, ry1;
        for (int i = 0; i < 10; i++) begin
            rx0 = $urandom_range(0, 660);
            ry0 = $urandom_range(0, 370);
            rx1 = rx0 + $urandom_range(0, 10);
            ry1 = ry0 + $urandom_range(0, 5);
            if ($urandom_range(0, 5) == 0 && rx0 > 0) rx1 = rx0 - 1;
            do_fill(rx0, ry0, rx1, ry1, $urandom_range(0, 63), 2, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_fill(100, 50, 104, 51, 'h0A, 0, 1'b0);
        do_fill(639, 0, 639, 2, 'h3E, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_small_rect();
        test_clamp();
        test_empty();
        test_stall();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
